// File: rtl/reg_file_readout_if.sv
// Bus bundle for reg_file_readout: readout request, register-file read port and output stream.
// The out_parity signal exists only when READOUT_PARITY_EN is defined.
interface reg_file_readout_if #(
  parameter int PW = 3
);
  logic          start;
  logic [PW-1:0] base_addr;
  logic [PW:0]   len;
  logic          busy;
  logic [PW:0]   rd_addr;
  logic [7:0]    rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [PW-1:0] out_addr;
  logic          out_last;
  logic          done;
`ifdef READOUT_PARITY_EN
  logic          out_parity;

  modport master (
    input  start, base_addr, len, rd_data, out_ready,
    output busy, rd_addr, out_valid, out_data, out_addr, out_last, done, out_parity
  );

  modport slave (
    output start, base_addr, len, rd_data, out_ready,
    input  busy, rd_addr, out_valid, out_data, out_addr, out_last, done, out_parity
  );
`else
  modport master (
    input  start, base_addr, len, rd_data, out_ready,
    output busy, rd_addr, out_valid, out_data, out_addr, out_last, done
  );

  modport slave (
    output start, base_addr, len, rd_data, out_ready,
    input  busy, rd_addr, out_valid, out_data, out_addr, out_last, done
  );
`endif
endinterface

// File: rtl/reg_file_readout.sv
// Sequential read-back engine: walks a wrapping range of the 8-bit register file and streams each
// byte with its index and a last flag. Define READOUT_PARITY_EN to add a registered out_parity.
module reg_file_readout #(
  parameter int PW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_file_readout_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [PW:0]   DEPTH   = {1'b1, {PW{1'b0}}};
  localparam logic [PW:0]   REM_ONE = (PW+1)'(1'b1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_rem;
  logic          r_busy;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_done;
  logic [7:0]    r_out_data;
  logic [PW-1:0] r_out_addr;
  logic [PW:0]   r_rd_addr;
  logic [PW:0]   w_len_clamped;
  logic [PW-1:0] w_ptr_next;
  logic          w_accept;

`ifdef READOUT_PARITY_EN
  logic r_out_parity;

  function automatic logic f_even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  // Cap the request at the file depth so each entry is read at most once per readout.
  always_comb begin
    w_len_clamped = bus.len;
    if (bus.len > DEPTH) begin
      w_len_clamped = DEPTH;
    end else begin
      w_len_clamped = bus.len;
    end
  end

  assign w_ptr_next = r_ptr + PTR_ONE;
  assign w_accept   = r_out_valid && bus.out_ready;

  // Readout FSM: IDLE waits for a request, FETCH captures rd_data, HOLD waits for acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= {PW{1'b0}};
      r_rem       <= {(PW+1){1'b0}};
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_addr  <= {PW{1'b0}};
      r_rd_addr   <= {(PW+1){1'b0}};
`ifdef READOUT_PARITY_EN
      r_out_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (bus.start && (bus.len != {(PW+1){1'b0}}) && !r_done) begin
            r_ptr     <= bus.base_addr;
            r_rem     <= w_len_clamped;
            r_rd_addr <= {1'b0, bus.base_addr};
            r_busy    <= 1'b1;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          r_out_data  <= bus.rd_data;
          r_out_addr  <= r_ptr;
          r_out_last  <= (r_rem == REM_ONE);
          r_out_valid <= 1'b1;
`ifdef READOUT_PARITY_EN
          r_out_parity <= f_even_parity(bus.rd_data);
`endif
          r_state     <= HOLD;
        end
        HOLD: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            if (r_rem == REM_ONE) begin
              r_out_last <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_ptr     <= w_ptr_next;
              r_rem     <= r_rem - REM_ONE;
              r_rd_addr <= {1'b0, w_ptr_next};
              r_state   <= FETCH;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_last  = r_out_last;
  assign bus.done      = r_done;
`ifdef READOUT_PARITY_EN
  assign bus.out_parity = r_out_parity;
`endif

endmodule
